load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's execute stage and the word-wide memory port; turns RISC-V byte/half/word loads and stores into aligned 32-bit memory transactions with byte strobes. Registers one request, drives the memory request/response handshake, extracts and sign/zero-extends load data, and reports misaligned, illegal-width and no-response faults. Exactly one transaction is outstanding at a time.

## Interface
- `TIMEOUT`, 16: cycles `mem_ready` may stay high without `mem_valid` before an access fault.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `lsu_valid` in 1: core presents a request.
- `lsu_ready` out 1: block can accept; high only in IDLE.
- `lsu_store` in 1: 1 = store, 0 = load.
- `lsu_funct3` in 3: RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `lsu_addr` in 32: byte address.
- `lsu_wdata` in 32: store data, LSB-justified.
- `lsu_rvalid` out 1: one-cycle completion pulse (loads and stores, faulted or not).
- `lsu_rdata` out 32: extended load data; 0 for stores and faults.
- `lsu_fault` out 2: 00 none, 01 misaligned, 10 access (timeout), 11 illegal funct3.
- `mem_ready` out 1: request to memory; held until response or timeout.
- `mem_valid` in 1: memory response pulse.
- `mem_addr` out 32: `{addr[31:2], 2'b00}`.
- `mem_wdata` out 32: replicated store data.
- `mem_wstrb` out 4: byte enables; 0000 for loads.
- `mem_rdata` in 32: read word, valid with `mem_valid`.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: `lsu_ready`=1. On `lsu_valid`, register store, funct3, addr, wdata. Check order: illegal funct3 (load 011/110/111, store ≥011) → fault 11; else misaligned (half with addr[0]=1, word with addr[1:0]≠0) → fault 01. Either goes straight to RESP, never raising `mem_ready`. Otherwise → REQ.
- REQ: `mem_ready`=1, address/strobe/data outputs stable. Timeout counter increments each REQ cycle. On `mem_valid`: capture extracted load data → RESP. If counter reaches `TIMEOUT-1` without `mem_valid`: fault 10 → RESP.
- RESP: `lsu_rvalid`=1 for exactly one cycle with `lsu_rdata`/`lsu_fault`; → IDLE.
- Strobes: byte `4'b0001 << addr[1:0]`, wdata `{4{wdata[7:0]}}`; half `addr[1] ? 1100 : 0011`, wdata `{2{wdata[15:0]}}`; word 1111, wdata unchanged.
- Load extract: `w = mem_rdata >> (8*addr[1:0])`; LB/LH sign-extend `w[7:0]`/`w[15:0]`; LBU/LHU zero-extend; LW `w`.
- `mem_valid` outside REQ is ignored. `lsu_valid` outside IDLE is ignored (core must hold until `lsu_ready`).
- Reset mid-REQ: outputs drop at once; a write already performed by memory is not rolled back.

## Timing
- Reset values: state IDLE, `lsu_ready`=1, `mem_ready`=0, `lsu_rvalid`=0, `lsu_rdata`=0, `lsu_fault`=00, `mem_addr`/`mem_wdata`=0, `mem_wstrb`=0000, counter 0.
- All outputs registered or decoded from registered state; no combinational path from `mem_valid`/`mem_rdata` to outputs.
- Accept edge E0 → `mem_ready` high after E0; memory responding next edge (E1) → `mem_valid` high after E1 → captured at E2, `mem_ready` low and `lsu_rvalid` high after E2 → IDLE after E3. Load-to-result: 3 cycles; back-to-back throughput one request per 4 cycles.
- Dropping `mem_ready` at E2 is required: memory re-issues if `mem_ready` is high while its `mem_valid` is low.
- Fault without access: `lsu_rvalid` 1 cycle after accept.
- Timeout: `mem_ready` high exactly `TIMEOUT` cycles, then RESP.

## Structure
- `lsu_pkg`: funct3 constants, `lsu_fault_e` (NONE, MISALIGN, ACCESS, ILLEGAL), `lsu_state_e`.
- Sub-module `lsu_align`: combinational strobe/wdata formatting, misalign/illegal checks, and load extraction; top holds FSM, registers, counter.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100 → `mem_wstrb`=1111; `lsu_rdata`=0xDEADBEEF 3 cycles after accept.
- SB 0x80 @0x103, then LB @0x103 / LBU @0x103 → `mem_wstrb`=1000, `mem_wdata`=0x80808080; `lsu_rdata`=0xFFFFFF80 / 0x00000080.
- LH @0x102 on word 0x8001_1234 → 0xFFFF8001; LHU → 0x00008001.
- LW @0x101, SH @0x103 → fault 01, `mem_ready` never high, `rvalid` 1 cycle after accept; funct3 011 load → fault 11.
- LW @0x0001_0000 (beyond 16384-word memory) → `mem_ready` high 16 cycles, then fault 10, `lsu_rdata`=0.
- Assert `reset` in REQ → `mem_ready`, `lsu_rvalid` low immediately, `lsu_ready`=1; next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Width codes follow the RV32I funct3 encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_ACCESS   = 2'b10,
        FAULT_ILLEGAL  = 2'b11
    } lsu_fault_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic       store;
        logic [2:0] funct3;
        logic [1:0] off;
    } lsu_req_t;

    function automatic logic [31:0] extend(
        input logic [15:0] v,
        input logic        half,
        input logic        sign
    );
        logic [31:0] r;
        if (half)
            r = {{16{sign & v[15]}}, v};
        else
            r = {{24{sign & v[7]}}, v[7:0]};
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Request formatting (strobes, replicated data, fault checks)
// and load-data extraction for the load/store unit.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    output logic [31:0] req_wdata_fmt,
    output logic        req_illegal,
    output logic        req_misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        req_illegal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: req_illegal = 1'b0;
            F3_BU, F3_HU:     req_illegal = req_store;
            default:          req_illegal = 1'b1;
        endcase
    end

    always_comb begin
        req_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_misalign = req_off[0];
            2'b10:   req_misalign = (req_off != 2'b00);
            default: req_misalign = 1'b0;
        endcase
    end

    always_comb begin
        req_wstrb     = 4'b1111;
        req_wdata_fmt = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                req_wstrb     = 4'b0001 << req_off;
                req_wdata_fmt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_wstrb     = req_off[1] ? 4'b1100 : 4'b0011;
                req_wdata_fmt = {2{req_wdata[15:0]}};
            end
            default: begin
                req_wstrb     = 4'b1111;
                req_wdata_fmt = req_wdata;
            end
        endcase
    end

    assign shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = shifted;
        case (ld_funct3)
            F3_B:    ld_data = extend(shifted[15:0], 1'b0, 1'b1);
            F3_H:    ld_data = extend(shifted[15:0], 1'b1, 1'b1);
            F3_BU:   ld_data = extend(shifted[15:0], 1'b0, 1'b0);
            F3_HU:   ld_data = extend(shifted[15:0], 1'b1, 1'b0);
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: request FSM, memory
// handshake with response timeout, and registered results.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        lsu_store,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_fault,
    output logic        mem_ready,
    input  logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_e  state;
    lsu_req_t    req_q;
    lsu_fault_e  fault_q;
    logic [CW-1:0] cnt;

    logic [3:0]  fmt_wstrb;
    logic [31:0] fmt_wdata;
    logic        chk_illegal;
    logic        chk_misalign;
    logic [31:0] ld_data;

    lsu_align u_align (
        .req_store     (lsu_store),
        .req_funct3    (lsu_funct3),
        .req_off       (lsu_addr[1:0]),
        .req_wdata     (lsu_wdata),
        .req_wstrb     (fmt_wstrb),
        .req_wdata_fmt (fmt_wdata),
        .req_illegal   (chk_illegal),
        .req_misalign  (chk_misalign),
        .ld_funct3     (req_q.funct3),
        .ld_off        (req_q.off),
        .ld_rdata      (mem_rdata),
        .ld_data       (ld_data)
    );

    assign lsu_fault = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            fault_q    <= FAULT_NONE;
            cnt        <= '0;
            lsu_ready  <= 1'b1;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
            mem_ready  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (lsu_valid) begin
                        req_q     <= '{lsu_store, lsu_funct3, lsu_addr[1:0]};
                        lsu_ready <= 1'b0;
                        cnt       <= '0;
                        if (chk_illegal || chk_misalign) begin
                            fault_q    <= chk_illegal ? FAULT_ILLEGAL
                                                      : FAULT_MISALIGN;
                            lsu_rvalid <= 1'b1;
                            lsu_rdata  <= '0;
                            state      <= ST_RESP;
                        end else begin
                            mem_ready <= 1'b1;
                            mem_addr  <= {lsu_addr[31:2], 2'b00};
                            mem_wdata <= fmt_wdata;
                            mem_wstrb <= lsu_store ? fmt_wstrb : 4'b0000;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // mem_valid wins over a timeout on the same edge
                    if (mem_valid || cnt == CNT_LAST) begin
                        mem_ready  <= 1'b0;
                        mem_addr   <= '0;
                        mem_wdata  <= '0;
                        mem_wstrb  <= '0;
                        lsu_rvalid <= 1'b1;
                        state      <= ST_RESP;
                        if (mem_valid) begin
                            fault_q   <= FAULT_NONE;
                            lsu_rdata <= req_q.store ? 32'h0 : ld_data;
                        end else begin
                            fault_q   <= FAULT_ACCESS;
                            lsu_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    lsu_rvalid <= 1'b0;
                    lsu_rdata  <= '0;
                    fault_q    <= FAULT_NONE;
                    lsu_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    lsu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16384-word
// memory model that answers one cycle after a request.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_fault;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:16383];
    logic        fire;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_store  (lsu_store),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .lsu_fault  (lsu_fault),
        .mem_ready  (mem_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign fire = mem_ready && !mem_valid && !reset
                  && (mem_addr < 32'h0001_0000);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_valid <= fire;
            if (fire)
                mem_rdata <= mem[mem_addr[15:2]];
        end
    end

    always @(posedge clk) begin
        if (fire) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b])
                    mem[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Issue one request and check result, latency and memory view.
    task automatic vec(
        input string       tag,
        input logic        st,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] exp_rd,
        input logic [1:0]  exp_ft,
        input int          exp_lat,
        input int          exp_rdy,
        input logic [3:0]  exp_strb,
        input logic [31:0] exp_wd
    );
        int          lat;
        int          rdy;
        logic [3:0]  strb;
        logic [31:0] wdo;
        logic [31:0] mad;
        @(negedge clk);
        check({tag, ".ready"}, 32'(lsu_ready), 32'd1);
        lsu_valid  = 1'b1;
        lsu_store  = st;
        lsu_funct3 = f3;
        lsu_addr   = a;
        lsu_wdata  = wd;
        @(negedge clk);
        lsu_valid = 1'b0;
        lsu_addr  = 32'hFFFF_FFFF;
        lsu_wdata = 32'h5555_5555;
        lat  = 1;
        rdy  = 0;
        strb = '0;
        wdo  = '0;
        mad  = '0;
        while (!lsu_rvalid && lat < 40) begin
            if (mem_ready) begin
                rdy++;
                strb = mem_wstrb;
                wdo  = mem_wdata;
                mad  = mem_addr;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, ".rvalid"}, 32'(lsu_rvalid), 32'd1);
        check({tag, ".rdata"}, lsu_rdata, exp_rd);
        check({tag, ".fault"}, 32'(lsu_fault), 32'(exp_ft));
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".memrdy"}, 32'(rdy), 32'(exp_rdy));
        if (exp_rdy > 0) begin
            check({tag, ".wstrb"}, 32'(strb), 32'(exp_strb));
            check({tag, ".maddr"}, mad, {a[31:2], 2'b00});
            if (st)
                check({tag, ".wdata"}, wdo, exp_wd);
        end
        @(negedge clk);
        check({tag, ".pulse"}, 32'(lsu_rvalid), 32'd0);
        check({tag, ".idle"}, 32'(lsu_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        lsu_valid  = 1'b0;
        lsu_store  = 1'b0;
        lsu_funct3 = 3'b000;
        lsu_addr   = '0;
        lsu_wdata  = '0;
        repeat (2) @(negedge clk);
        check("rst.lsu_ready", 32'(lsu_ready), 32'd1);
        check("rst.mem_ready", 32'(mem_ready), 32'd0);
        check("rst.rvalid", 32'(lsu_rvalid), 32'd0);
        check("rst.rdata", lsu_rdata, 32'h0);
        check("rst.fault", 32'(lsu_fault), 32'd0);
        check("rst.maddr", mem_addr, 32'h0);
        check("rst.mwdata", mem_wdata, 32'h0);
        check("rst.wstrb", 32'(mem_wstrb), 32'd0);
        reset = 1'b0;

        vec("sw", 1, 3'b010, 32'h100, 32'hDEAD_BEEF,
            32'h0, 2'b00, 3, 2, 4'b1111, 32'hDEAD_BEEF);
        vec("lw", 0, 3'b010, 32'h100, 32'h0,
            32'hDEAD_BEEF, 2'b00, 3, 2, 4'b0000, 32'h0);
        vec("sb", 1, 3'b000, 32'h103, 32'h0000_0080,
            32'h0, 2'b00, 3, 2, 4'b1000, 32'h8080_8080);
        vec("lb", 0, 3'b000, 32'h103, 32'h0,
            32'hFFFF_FF80, 2'b00, 3, 2, 4'b0000, 32'h0);
        vec("lbu", 0, 3'b100, 32'h103, 32'h0,
            32'h0000_0080, 2'b00, 3, 2, 4'b0000, 32'h0);
        vec("sw2", 1, 3'b010, 32'h200, 32'h8001_1234,
            32'h0, 2'b00, 3, 2, 4'b1111, 32'h8001_1234);
        vec("lh", 0, 3'b001, 32'h202, 32'h0,
            32'hFFFF_8001, 2'b00, 3, 2, 4'b0000, 32'h0);
        vec("lhu", 0, 3'b101, 32'h202, 32'h0,
            32'h0000_8001, 2'b00, 3, 2, 4'b0000, 32'h0);
        vec("lh0", 0, 3'b001, 32'h200, 32'h0,
            32'h0000_1234, 2'b00, 3, 2, 4'b0000, 32'h0);
        vec("lb1", 0, 3'b000, 32'h201, 32'h0,
            32'h0000_0012, 2'b00, 3, 2, 4'b0000, 32'h0);
        vec("sh", 1, 3'b001, 32'h102, 32'hABCD_1234,
            32'h0, 2'b00, 3, 2, 4'b1100, 32'h1234_1234);
        vec("lw2", 0, 3'b010, 32'h100, 32'h0,
            32'h1234_BEEF, 2'b00, 3, 2, 4'b0000, 32'h0);
        vec("lw_mis", 0, 3'b010, 32'h101, 32'h0,
            32'h0, 2'b01, 1, 0, 4'b0000, 32'h0);
        vec("sh_mis", 1, 3'b001, 32'h103, 32'hFFFF,
            32'h0, 2'b01, 1, 0, 4'b0000, 32'h0);
        vec("ld_ill", 0, 3'b011, 32'h100, 32'h0,
            32'h0, 2'b11, 1, 0, 4'b0000, 32'h0);
        vec("st_ill", 1, 3'b100, 32'h101, 32'h0,
            32'h0, 2'b11, 1, 0, 4'b0000, 32'h0);
        vec("lw_to", 0, 3'b010, 32'h0001_0000, 32'h0,
            32'h0, 2'b10, 17, 16, 4'b0000, 32'h0);

        @(negedge clk);
        lsu_valid  = 1'b1;
        lsu_store  = 1'b0;
        lsu_funct3 = 3'b010;
        lsu_addr   = 32'h100;
        @(negedge clk);
        lsu_valid = 1'b0;
        check("mid.mem_ready", 32'(mem_ready), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mid.mem_ready_rst", 32'(mem_ready), 32'd0);
        check("mid.rvalid_rst", 32'(lsu_rvalid), 32'd0);
        check("mid.lsu_ready_rst", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        vec("post_rst", 0, 3'b010, 32'h200, 32'h0,
            32'h8001_1234, 2'b00, 3, 2, 4'b0000, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
